// File: rtl/pipe_pkg.sv
// Shared widths and FSM encoding for the data-memory responder.
package pipe_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM with per-byte write enables and registered read data.
module dmem_bank
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read register only moves on loads, so it holds across store responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pipe_dmem_responder.sv
// MEM-stage data-memory target: handshake, latency timer and request latch.
// Optional misaligned-address error reporting under DMEM_ALIGN_CHECK_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request, nothing outstanding
// ST_WAIT | request latched, latency counter running, not ready
// ST_RESP | access done on entry edge, rsp_valid high, ready again
module pipe_dmem_responder
    import pipe_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [ADDR_W-1:0] idx_q;
    logic [WORD_W-1:0] wdata_q;

    logic              accept;
    logic              mem_go;
    logic              misaligned;
    logic              acc_we;
    logic [BE_W-1:0]   acc_be;
    logic [ADDR_W-1:0] acc_idx;
    logic [WORD_W-1:0] acc_wdata;

    assign req_ready = !clrn && (state_q != ST_WAIT);
    assign busy      = (state_q == ST_WAIT);
    assign rsp_valid = (state_q == ST_RESP);
    assign accept    = req_valid && req_ready;

    // With LATENCY=1 the access shares the accept edge, so use the live inputs.
    assign acc_we    = accept ? req_we                  : we_q;
    assign acc_be    = accept ? req_be                  : be_q;
    assign acc_idx   = accept ? req_addr[ADDR_W+1:2]    : idx_q;
    assign acc_wdata = accept ? req_wdata               : wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mem_go = (state_d == ST_RESP);

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                be_q    <= req_be;
                idx_q   <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] lo_q;
    logic [1:0] acc_lo;
    logic       err_q;

    assign acc_lo     = accept ? req_addr[1:0] : lo_q;
    assign misaligned = (acc_lo != 2'b00);

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            lo_q  <= 2'b00;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                lo_q <= req_addr[1:0];
            end
            if (mem_go) begin
                err_q <= misaligned;
            end
        end
    end

    assign rsp_err = err_q;

    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, req_addr[31:ADDR_W+2]};
`else
    assign misaligned = 1'b0;
    assign rsp_err    = 1'b0;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

    dmem_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk_i   (clk),
        .rst_i   (clrn),
        .en_i    (mem_go && !misaligned),
        .we_i    (acc_we),
        .be_i    (acc_be),
        .addr_i  (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (rsp_rdata)
    );

endmodule

// File: tb/tb_pipe_dmem_responder.sv
// Directed bench: one responder at LATENCY=2 and one at LATENCY=3.
module tb_pipe_dmem_responder;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err, a_busy;
    logic [3:0]  a_req_be;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err, b_busy;
    logic [3:0]  b_req_be;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

    int checks = 0;
    int failures = 0;

    pipe_dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk(clk), .clrn(clrn),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_be(a_req_be), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .busy(a_busy)
    );

    pipe_dmem_responder #(.ADDR_W(10), .LATENCY(3)) dut3 (
        .clk(clk), .clrn(clrn),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_be(b_req_be), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .busy(b_busy)
    );

    function automatic logic rdy(input bit sel);
        return sel ? b_req_ready : a_req_ready;
    endfunction
    function automatic logic rv(input bit sel);
        return sel ? b_rsp_valid : a_rsp_valid;
    endfunction
    function automatic logic bsy(input bit sel);
        return sel ? b_busy : a_busy;
    endfunction
    function automatic logic [31:0] rdat(input bit sel);
        return sel ? b_rsp_rdata : a_rsp_rdata;
    endfunction
    function automatic logic rer(input bit sel);
        return sel ? b_rsp_err : a_rsp_err;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            b_req_valid = v; b_req_we = we; b_req_be = be; b_req_addr = addr; b_req_wdata = wdata;
        end else begin
            a_req_valid = v; a_req_we = we; a_req_be = be; a_req_addr = addr; a_req_wdata = wdata;
        end
    endtask

    // One request; lat counts cycles from accept edge to the rsp_valid cycle.
    task automatic do_req(input bit sel, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic rdy1, output logic bsy1, output logic pulse2);
        int n;
        @(negedge clk);
        drive(sel, 1'b1, we, be, addr, wdata);
        n = 0;
        while (!rdy(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rdy1 = rdy(sel);
        bsy1 = bsy(sel);
        lat = 1;
        while (!rv(sel) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rdat(sel);
        er = rer(sel);
        @(negedge clk);
        pulse2 = rv(sel);
    endtask

    task automatic test_reset();
        clrn = 1'b1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if ({a_rsp_valid, a_rsp_err, a_busy, a_req_ready, a_rsp_rdata} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {a_rsp_valid, a_rsp_err, a_busy, a_req_ready, a_rsp_rdata});
        end
        clrn = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_req_ready, a_busy, b_req_ready, b_busy} !== 4'b1010) begin
            failures++;
            $display("FAIL post_reset_ready got=%b want=1010", {a_req_ready, a_busy, b_req_ready, b_busy});
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er, r1, b1, p2;
        do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, er, r1, b1, p2);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL store_latency got=%0d want=2", lat); end
        checks++;
        if ({r1, b1} !== 2'b01) begin failures++; $display("FAIL wait_ready_busy got=%b want=01", {r1, b1}); end
        checks++;
        if (p2 !== 1'b0) begin failures++; $display("FAIL store_pulse_width got=%b want=0", p2); end
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL store_rdata_hold got=%h want=00000000", rd); end
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, r1, b1, p2);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL load_latency got=%0d want=2", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data got=%h want=deadbeef", rd); end
        checks++;
        if (er !== 1'b0) begin failures++; $display("FAIL load_err got=%b want=0", er); end
    endtask

    task automatic test_byte_store();
        int lat; logic [31:0] rd; logic er, r1, b1, p2;
        do_req(0, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, lat, rd, er, r1, b1, p2);
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL byte_store_rdata_hold got=%h want=deadbeef", rd); end
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, r1, b1, p2);
        checks++;
        if (rd !== 32'hDEADAAEF) begin failures++; $display("FAIL byte_store_data got=%h want=deadaaef", rd); end
        do_req(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, lat, rd, er, r1, b1, p2);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL be0_ack_latency got=%0d want=2", lat); end
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, r1, b1, p2);
        checks++;
        if (rd !== 32'hDEADAAEF) begin failures++; $display("FAIL be0_unchanged got=%h want=deadaaef", rd); end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rd; logic er, r1, b1, p2;
        do_req(0, 1'b1, 4'hF, 32'h1000, 32'h00001234, lat, rd, er, r1, b1, p2);
        do_req(0, 1'b0, 4'h0, 32'h0000, 32'h0, lat, rd, er, r1, b1, p2);
        checks++;
        if (rd !== 32'h00001234) begin failures++; $display("FAIL wrap_data got=%h want=00001234", rd); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er, r1, b1, p2;
        int acc [4];
        logic [31:0] rdv [4];
        int na, nr;
        logic prev, upd, wide, rdy_bad;
        for (int i = 0; i < 4; i++) begin
            do_req(1, 1'b1, 4'hF, 32'(i * 4), 32'hA0000000 + 32'(i), lat, rd, er, r1, b1, p2);
        end
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL l3_latency got=%0d want=3", lat); end
        na = 0; nr = 0; prev = 1'b0; upd = 1'b0; wide = 1'b0; rdy_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin acc[i] = -1; rdv[i] = 32'h0; end
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 40; k++) begin
            if (upd) begin
                if (na < 4) b_req_addr = 32'(na * 4);
                else b_req_valid = 1'b0;
                upd = 1'b0;
            end
            if (b_rsp_valid) begin
                if (nr < 4) rdv[nr] = b_rsp_rdata;
                nr++;
                if (prev) wide = 1'b1;
            end
            prev = b_rsp_valid;
            if (b_busy && b_req_ready) rdy_bad = 1'b1;
            if (b_req_valid && b_req_ready) begin
                if (na < 4) acc[na] = k;
                na++;
                upd = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (na !== 4 || nr !== 4) begin failures++; $display("FAIL b2b_counts got=%0d/%0d want=4/4", na, nr); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc[i+1] - acc[i] !== 3) begin
                failures++;
                $display("FAIL b2b_spacing idx=%0d got=%0d want=3", i, acc[i+1] - acc[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdv[i] !== 32'hA0000000 + 32'(i)) begin
                failures++;
                $display("FAIL b2b_data idx=%0d got=%h want=%h", i, rdv[i], 32'hA0000000 + 32'(i));
            end
        end
        checks++;
        if ({wide, rdy_bad} !== 2'b00) begin failures++; $display("FAIL b2b_pulse_ready got=%b want=00", {wide, rdy_bad}); end
    endtask

    task automatic test_reset_midop();
        int lat; logic [31:0] rd; logic er, r1, b1, p2;
        logic seen;
        do_req(0, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, lat, rd, er, r1, b1, p2);
        do_req(0, 1'b0, 4'h0, 32'h20, 32'h0, lat, rd, er, r1, b1, p2);
        checks++;
        if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL midop_setup got=%h want=cafef00d", rd); end
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h00000055);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (a_busy !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b want=1", a_busy); end
        clrn = 1'b1;
        #1;
        checks++;
        if ({a_rsp_valid, a_rsp_err, a_busy, a_req_ready, a_rsp_rdata} !== 36'h0) begin
            failures++;
            $display("FAIL midop_reset_outputs got=%h want=0",
                     {a_rsp_valid, a_rsp_err, a_busy, a_req_ready, a_rsp_rdata});
        end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (a_rsp_valid) seen = 1'b1; end
        clrn = 1'b0;
        repeat (4) begin @(negedge clk); if (a_rsp_valid) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL midop_no_response got=%b want=0", seen); end
        do_req(0, 1'b0, 4'h0, 32'h20, 32'h0, lat, rd, er, r1, b1, p2);
        checks++;
        if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL midop_store_dropped got=%h want=cafef00d", rd); end
    endtask

    task automatic test_align();
        int lat; logic [31:0] rd; logic er, r1, b1, p2;
`ifdef DMEM_ALIGN_CHECK_EN
        do_req(0, 1'b0, 4'h0, 32'h13, 32'h0, lat, rd, er, r1, b1, p2);
        checks++;
        if ({lat == 2, er} !== 2'b11) begin failures++; $display("FAIL align_err got_lat=%0d got_err=%b want=2/1", lat, er); end
        checks++;
        if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL align_rdata_hold got=%h want=cafef00d", rd); end
        do_req(0, 1'b1, 4'hF, 32'h12, 32'h0, lat, rd, er, r1, b1, p2);
        checks++;
        if (er !== 1'b1) begin failures++; $display("FAIL align_store_err got=%b want=1", er); end
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er, r1, b1, p2);
        checks++;
        if ({er, rd} !== {1'b0, 32'hDEADAAEF}) begin
            failures++;
            $display("FAIL align_clear got_err=%b got_data=%h want=0/deadaaef", er, rd);
        end
`else
        do_req(0, 1'b0, 4'h0, 32'h13, 32'h0, lat, rd, er, r1, b1, p2);
        checks++;
        if ({er, rd} !== {1'b0, 32'hDEADAAEF}) begin
            failures++;
            $display("FAIL unaligned_ignored got_err=%b got_data=%h want=0/deadaaef", er, rd);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_store();
        test_wrap();
        test_back_to_back();
        test_reset_midop();
        test_align();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
